if_prefetch_stage: RTL and testbench

- Parametrised instruction-fetch stage for the ARM pipeline. It replaces the single IF/ID register with a FIFO_DEPTH-entry prefetch buffer.
- Fetch runs ahead of the decode stage while decode is frozen. The buffer is flushed on a taken branch or an explicit flush.
- Instruction memory sits outside the block. It is addressed with imem_addr and read combinationally the same cycle.
- Output pc follows the ARM convention: it is the address of the presented instruction plus PC_STEP.

---
 rtl/if_prefetch_stage.sv | 101 ++++++++++
 tb/tb_if_prefetch_stage.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/if_prefetch_stage.sv
// Instruction-fetch stage with a register-based prefetch FIFO between fetch and decode.
// Fetch runs ahead while decode is frozen; branch_taken or flush discards the buffer.
module if_prefetch_stage #(
    parameter int ADDR_W     = 32,
    parameter int INST_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int PC_STEP    = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            freeze,
    input  logic                            flush,
    input  logic                            branch_taken,
    input  logic [ADDR_W-1:0]               branch_addr,
    output logic [ADDR_W-1:0]               imem_addr,
    input  logic [INST_W-1:0]               imem_data,
    output logic [INST_W-1:0]               instruction,
    output logic [ADDR_W-1:0]               pc,
    output logic                            valid,
    output logic [$clog2(FIFO_DEPTH):0]     fill_level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [ADDR_W-1:0] pc_mem_q   [FIFO_DEPTH];
    logic [INST_W-1:0] inst_mem_q [FIFO_DEPTH];

    logic redirect, pop, push;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;

        redirect = branch_taken || flush;
        pop      = valid && !freeze;
        push     = !redirect && ((count_q < CNT_W'(FIFO_DEPTH)) || pop);

        if (branch_taken) begin
            fetch_pc_d = branch_addr;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
                wr_ptr_d   = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // NOTE: entry storage is not reset; outputs are masked by valid, so stale data is never visible.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]   <= fetch_pc_q + ADDR_W'(PC_STEP);
            inst_mem_q[wr_ptr_q] <= imem_data;
        end
    end

    assign imem_addr   = fetch_pc_q;
    assign valid       = (count_q != '0);
    assign fill_level  = count_q;
    assign instruction = valid ? inst_mem_q[rd_ptr_q] : '0;
    assign pc          = valid ? pc_mem_q[rd_ptr_q]   : '0;

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Directed, table-driven bench for if_prefetch_stage with a combinational imem model
// (imem_data = E000_0000 | imem_addr).
module tb_if_prefetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze, flush, branch_taken;
    logic [31:0] branch_addr;
    logic [31:0] imem_addr, imem_data, instruction, pc;
    logic        valid;
    logic [2:0]  fill_level;

    int checks = 0;
    int errors = 0;

    if_prefetch_stage #(.ADDR_W(32), .INST_W(32), .FIFO_DEPTH(4), .PC_STEP(4)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .branch_taken(branch_taken), .branch_addr(branch_addr),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .instruction(instruction), .pc(pc), .valid(valid), .fill_level(fill_level)
    );

    always #5 clk = ~clk;
    assign imem_data = 32'hE000_0000 | imem_addr;

    typedef struct {
        logic        rst, frz, fl, br;
        logic [31:0] baddr;
        logic        ev;
        logic [31:0] head;
        logic [2:0]  fill;
        logic [31:0] addr;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [vec %0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    // Expected instruction/pc are derived from the head entry's fetch address.
    task automatic check_outputs(input int idx, input logic ev, input logic [31:0] head,
                                 input logic [2:0] fill, input logic [31:0] addr);
        check("valid", idx, 32'(valid), 32'(ev));
        check("instruction", idx, instruction, ev ? (32'hE000_0000 | head) : 32'h0);
        check("pc", idx, pc, ev ? head + 32'd4 : 32'h0);
        check("fill_level", idx, 32'(fill_level), 32'(fill));
        check("imem_addr", idx, imem_addr, addr);
    endtask

    function automatic vec_t mk(logic r, logic fz, logic fl, logic br, logic [31:0] ba,
                                logic ev, logic [31:0] hd, logic [2:0] fi, logic [31:0] ad);
        vec_t v;
        v.rst = r; v.frz = fz; v.fl = fl; v.br = br; v.baddr = ba;
        v.ev = ev; v.head = hd; v.fill = fi; v.addr = ad;
        return v;
    endfunction

    function automatic vec_t run(logic [31:0] hd, logic [2:0] fi, logic [31:0] ad);
        return mk(0, 0, 0, 0, 0, 1, hd, fi, ad);
    endfunction

    function automatic vec_t frz(logic [31:0] hd, logic [2:0] fi, logic [31:0] ad);
        return mk(0, 1, 0, 0, 0, 1, hd, fi, ad);
    endfunction

    function automatic vec_t rst_v();
        return mk(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    initial begin
        rst = 1'b1; freeze = 1'b0; flush = 1'b0; branch_taken = 1'b0; branch_addr = '0;

        // Free run from reset: one instruction per cycle, fill steady at 1.
        vecs.push_back(run(32'h00, 1, 32'h04));
        vecs.push_back(run(32'h04, 1, 32'h08));
        vecs.push_back(run(32'h08, 1, 32'h0C));
        vecs.push_back(run(32'h0C, 1, 32'h10));
        vecs.push_back(run(32'h10, 1, 32'h14));
        // Freeze for 8 cycles: fills to 4, fetch holds at 0x20, head holds.
        vecs.push_back(frz(32'h10, 2, 32'h18));
        vecs.push_back(frz(32'h10, 3, 32'h1C));
        for (int i = 0; i < 6; i++) vecs.push_back(frz(32'h10, 4, 32'h20));
        // Release: no gap, no duplicate, full FIFO pops and pushes together.
        vecs.push_back(run(32'h14, 4, 32'h24));
        vecs.push_back(run(32'h18, 4, 32'h28));
        vecs.push_back(run(32'h1C, 4, 32'h2C));
        vecs.push_back(run(32'h20, 4, 32'h30));
        // Branch to 0x40 with 3 entries buffered.
        vecs.push_back(rst_v());
        vecs.push_back(run(32'h00, 1, 32'h04));
        vecs.push_back(frz(32'h00, 2, 32'h08));
        vecs.push_back(frz(32'h00, 3, 32'h0C));
        vecs.push_back(mk(0, 0, 0, 1, 32'h40, 0, 0, 0, 32'h40));
        vecs.push_back(run(32'h40, 1, 32'h44));
        // Flush with 0x10..0x18 buffered and fetch_pc at 0x1C.
        vecs.push_back(rst_v());
        vecs.push_back(run(32'h00, 1, 32'h04));
        vecs.push_back(run(32'h04, 1, 32'h08));
        vecs.push_back(run(32'h08, 1, 32'h0C));
        vecs.push_back(run(32'h0C, 1, 32'h10));
        vecs.push_back(run(32'h10, 1, 32'h14));
        vecs.push_back(frz(32'h10, 2, 32'h18));
        vecs.push_back(frz(32'h10, 3, 32'h1C));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 32'h1C));
        vecs.push_back(run(32'h1C, 1, 32'h20));
        vecs.push_back(run(32'h20, 1, 32'h24));
        // Branch + freeze + full FIFO: redirect wins, target then held under freeze.
        vecs.push_back(frz(32'h20, 2, 32'h28));
        vecs.push_back(frz(32'h20, 3, 32'h2C));
        vecs.push_back(frz(32'h20, 4, 32'h30));
        vecs.push_back(mk(0, 1, 0, 1, 32'h80, 0, 0, 0, 32'h80));
        vecs.push_back(frz(32'h80, 1, 32'h84));
        vecs.push_back(frz(32'h80, 2, 32'h88));
        vecs.push_back(frz(32'h80, 3, 32'h8C));
        // Setup for the asynchronous reset sequence: fill_level = 2.
        vecs.push_back(rst_v());
        vecs.push_back(run(32'h00, 1, 32'h04));
        vecs.push_back(frz(32'h00, 2, 32'h08));

        #50;
        check_outputs(-1, 0, 0, 0, 0);
        #2 rst = 1'b0;

        foreach (vecs[i]) begin
            rst = vecs[i].rst; freeze = vecs[i].frz; flush = vecs[i].fl;
            branch_taken = vecs[i].br; branch_addr = vecs[i].baddr;
            @(posedge clk);
            #1;
            check_outputs(i, vecs[i].ev, vecs[i].head, vecs[i].fill, vecs[i].addr);
        end

        // Asynchronous reset pulse between edges clears outputs before the next edge.
        rst = 0; freeze = 1; flush = 0; branch_taken = 0;
        #1 rst = 1'b1;
        #3 rst = 1'b0;
        check_outputs(100, 0, 0, 0, 0);
        freeze = 1'b0;
        @(posedge clk);
        #1;
        check_outputs(101, 1, 32'h00, 1, 32'h04);
        @(posedge clk);
        #1;
        check_outputs(102, 1, 32'h04, 1, 32'h08);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
